varint_encoder: RTL and testbench

VARINT_ENCODER -- requirements
Module: varint_encoder

---
 rtl/varint_encoder.sv | 110 +++++++++++
 tb/tb_varint_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/varint_encoder.sv
// rtl/varint_encoder.sv - LSB-first LEB128 varint encoder with optional zigzag mapping.
// Emits one byte per cycle into a downstream FIFO, then holds data_valid at message end.
module varint_encoder #(
    parameter int VALUE_W = 64,
    parameter int INDEX_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VALUE_W-1:0] in_value,
    input  logic               in_zigzag,
    input  logic [INDEX_W-1:0] in_index,
    input  logic               in_last,
    input  logic               varint_fifo_full,
    output logic               varint_fifo_push,
    output logic [7:0]         varint_fifo_data,
    output logic [INDEX_W-1:0] varint_index_data,
    output logic               varint_data_valid,
    input  logic               varint_data_accepted
);

    typedef enum logic [1:0] {IDLE, EMIT, WAIT_ACC} state_t;

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] sr_q, sr_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic               last_q, last_d;
    logic               push_q, push_d;
    logic [7:0]         data_q, data_d;
    logic [INDEX_W-1:0] index_data_q, index_data_d;
    logic               valid_q, valid_d;
    logic [VALUE_W-1:0] zz_value;
    logic               cont;

    // Zigzag: shift left and flip all bits when the value is negative.
    assign zz_value = (in_value << 1) ^ {VALUE_W{in_value[VALUE_W-1]}};
    assign cont     = |(sr_q >> 7);

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        idx_d        = idx_q;
        last_d       = last_q;
        push_d       = 1'b0;
        data_d       = data_q;
        index_data_d = index_data_q;
        valid_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = in_zigzag ? zz_value : in_value;
                    idx_d   = in_index;
                    last_d  = in_last;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (!varint_fifo_full) begin
                    push_d       = 1'b1;
                    data_d       = {cont, sr_q[6:0]};
                    index_data_d = idx_q;
                    sr_d         = sr_q >> 7;
                    idx_d        = idx_q + 1'b1;
                    if (!cont) begin
                        state_d = last_q ? WAIT_ACC : IDLE;
                    end
                end
            end
            WAIT_ACC: begin
                // valid rises the cycle after the final push; acceptance counts only once it is visible
                if (valid_q && varint_data_accepted) begin
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            push_q       <= 1'b0;
            data_q       <= 8'h00;
            index_data_q <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            push_q       <= push_d;
            data_q       <= data_d;
            index_data_q <= index_data_d;
            valid_q      <= valid_d;
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign varint_fifo_push  = push_q;
    assign varint_fifo_data  = data_q;
    assign varint_index_data = index_data_q;
    assign varint_data_valid = valid_q;

endmodule

// File: tb/tb_varint_encoder.sv
// tb/tb_varint_encoder.sv - randomized and directed bench for varint_encoder against an arithmetic LEB128 model.
module tb_varint_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic        in_zigzag;
    logic [9:0]  in_index;
    logic        in_last;
    logic        varint_fifo_full;
    logic        varint_fifo_push;
    logic [7:0]  varint_fifo_data;
    logic [9:0]  varint_index_data;
    logic        varint_data_valid;
    logic        varint_data_accepted;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_b[$];
    logic [9:0] exp_i[$];
    logic [7:0] cap_b[$];
    logic [9:0] cap_i[$];

    always #5 clk = ~clk;

    varint_encoder #(.VALUE_W(64), .INDEX_W(10)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_value             (in_value),
        .in_zigzag            (in_zigzag),
        .in_index             (in_index),
        .in_last              (in_last),
        .varint_fifo_full     (varint_fifo_full),
        .varint_fifo_push     (varint_fifo_push),
        .varint_fifo_data     (varint_fifo_data),
        .varint_index_data    (varint_index_data),
        .varint_data_valid    (varint_data_valid),
        .varint_data_accepted (varint_data_accepted)
    );

    always @(negedge clk) begin
        if (varint_fifo_push) begin
            cap_b.push_back(varint_fifo_data);
            cap_i.push_back(varint_index_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] capb(input int k);
        return (k < cap_b.size()) ? 64'(cap_b[k]) : 64'hDEAD;
    endfunction

    function automatic logic [63:0] capi(input int k);
        return (k < cap_i.size()) ? 64'(cap_i[k]) : 64'hDEAD;
    endfunction

    // Reference: sint maps n>=0 to 2n and n<0 to 2|n|-1, then base-128 digits, low digit first.
    function automatic void model(input logic [63:0] v, input bit zz, input logic [9:0] idx);
        logic [63:0] u;
        logic [63:0] digit;
        logic [9:0]  p;
        longint      s;
        exp_b.delete();
        exp_i.delete();
        s = v;
        if (zz) u = (s < 0) ? 64'(2 * (-(s + 1))) + 64'd1 : 64'(2 * s);
        else    u = v;
        p = idx;
        do begin
            digit = u % 128;
            u     = u / 128;
            exp_b.push_back({(u != 0), digit[6:0]});
            exp_i.push_back(p);
            p = p + 10'd1;
        end while (u != 0);
    endfunction

    task automatic send(input logic [63:0] v, input bit zz, input logic [9:0] idx,
                        input bit last, input int stall);
        int t;
        model(v, zz, idx);
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("ready_before_send", in_ready, 1'b1);
        cap_b.delete();
        cap_i.delete();
        in_value  = v;
        in_zigzag = zz;
        in_index  = idx;
        in_last   = last;
        in_valid  = 1'b1;
        varint_fifo_full = (stall > 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ready_after_accept", in_ready, 1'b0);
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                @(posedge clk);
            end
            #1;
            chk("stall_no_push", cap_b.size(), 0);
            varint_fifo_full = 1'b0;
        end
        t = 0;
        while (cap_b.size() < exp_b.size() && t < 50) begin
            @(posedge clk); #1; t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("push_count", cap_b.size(), exp_b.size());
        for (int k = 0; k < exp_b.size(); k++) begin
            chk("byte", capb(k), 64'(exp_b[k]));
            chk("index", capi(k), 64'(exp_i[k]));
        end
        if (last) begin
            chk("data_valid_high", varint_data_valid, 1'b1);
            chk("ready_low_wait", in_ready, 1'b0);
            varint_data_accepted = 1'b1;
            @(posedge clk); #1;
            varint_data_accepted = 1'b0;
            chk("data_valid_low", varint_data_valid, 1'b0);
            chk("ready_after_acc", in_ready, 1'b1);
        end else begin
            chk("data_valid_nonlast", varint_data_valid, 1'b0);
            chk("ready_nonlast", in_ready, 1'b1);
        end
    endtask

    initial begin
        int t;
        logic [63:0] rv;
        reset = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        in_zigzag = 1'b0;
        in_index = '0;
        in_last = 1'b0;
        varint_fifo_full = 1'b0;
        varint_data_accepted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_push", varint_fifo_push, 1'b0);
        chk("rst_valid", varint_data_valid, 1'b0);
        chk("rst_data", varint_fifo_data, 8'h00);
        chk("rst_index", varint_index_data, 10'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        send(64'd300, 1'b0, 10'd5, 1'b1, 0);
        chk("d300_b0", capb(0), 64'hAC);
        chk("d300_i0", capi(0), 64'd5);
        chk("d300_b1", capb(1), 64'h02);
        chk("d300_i1", capi(1), 64'd6);

        send(64'd0, 1'b0, 10'd0, 1'b0, 0);
        chk("zero_n", cap_b.size(), 1);
        chk("zero_b", capb(0), 64'h00);
        chk("zero_i", capi(0), 64'd0);

        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10'd0, 1'b0, 0);
        chk("max_n", cap_b.size(), 10);
        chk("max_b0", capb(0), 64'hFF);
        chk("max_b8", capb(8), 64'hFF);
        chk("max_b9", capb(9), 64'h01);
        chk("max_i9", capi(9), 64'd9);

        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 10'd0, 1'b0, 0);
        chk("zz_m1", capb(0), 64'h01);
        send(64'd1, 1'b1, 10'd0, 1'b0, 0);
        chk("zz_p1", capb(0), 64'h02);
        send(-64'sd64, 1'b1, 10'd0, 1'b0, 0);
        chk("zz_m64", capb(0), 64'h7F);
        chk("zz_m64_n", cap_b.size(), 1);

        send(64'd300, 1'b0, 10'd5, 1'b0, 3);
        chk("stall_b0", capb(0), 64'hAC);
        chk("stall_b1", capb(1), 64'h02);

        send(64'd16384, 1'b0, 10'd1022, 1'b0, 0);
        chk("wrap_b0", capb(0), 64'h80);
        chk("wrap_i0", capi(0), 64'd1022);
        chk("wrap_b1", capb(1), 64'h80);
        chk("wrap_i1", capi(1), 64'd1023);
        chk("wrap_b2", capb(2), 64'h01);
        chk("wrap_i2", capi(2), 64'd0);

        // reset in the middle of a ten-byte value
        cap_b.delete();
        cap_i.delete();
        in_value  = 64'hFFFF_FFFF_FFFF_FFFF;
        in_zigzag = 1'b0;
        in_index  = 10'd0;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (cap_b.size() < 1 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("mid_first_push", cap_b.size(), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_push", varint_fifo_push, 1'b0);
        chk("mid_rst_data", varint_fifo_data, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("mid_no_more_push", cap_b.size(), 1);
        chk("mid_ready_after", in_ready, 1'b1);
        chk("mid_valid_after", varint_data_valid, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rv = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            send(rv, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
